multi_debouncer: RTL and testbench

Parametrised N-channel push-button/switch debouncer. Each channel synchronises one glitchy asynchronous input and applies configurable polarity. It filters the input with a saturating stability counter, optionally advanced by a shared sample strobe. It produces a clean level, one-cycle press/release pulses and a long-press indication. Sits between board button/switch pins and control logic, and replaces per-button single-channel debouncers.

---
 rtl/debounce_pkg.sv | 12 +
 rtl/debounce_channel.sv | 115 +++++++++++
 rtl/multi_debouncer.sv | 39 +++
 tb/tb_multi_debouncer.sv | 394 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared constants and helpers for the push-button debouncer family.
package debounce_pkg;

   // Depth of the per-channel input synchroniser.
   localparam int SYNC_STAGES = 2;

   // Width needed to hold a count of 0..ticks inclusive.
   function automatic int hold_w(input int ticks);
      return $clog2(ticks + 1);
   endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounced input: polarity fix, 2-FF synchroniser, saturating stability
// counter, hold (long-press) counter and registered event pulses.
module debounce_channel
   import debounce_pkg::*;
#(
   parameter int CNT_W      = 4,
   parameter bit POL_LOW    = 1'b1,
   parameter int HOLD_TICKS = 1000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic sample_en,
   input  logic raw_i,
   output logic state_o,
   output logic press_o,
   output logic release_o,
   output logic long_o,
   output logic held_long_o
);

   localparam int               HOLD_W   = hold_w(HOLD_TICKS);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_TICKS);
   localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);

   logic                   pol_s;
   logic                   idle_s;
   logic [SYNC_STAGES-1:0] sync_r;
   logic [CNT_W-1:0]       cnt_r,   cnt_s;
   logic [HOLD_W-1:0]      hold_r,  hold_s;
   logic                   state_r, state_s;
   logic                   press_r, press_s;
   logic                   rel_r,   rel_s;
   logic                   long_r,  long_s;
   logic                   held_r,  held_s;

   // Internal level is always 1 = active, whatever the pin polarity.
   assign pol_s  = raw_i ^ POL_LOW;
   // Synchronised input agrees with the debounced level: nothing to filter.
   assign idle_s = (sync_r[SYNC_STAGES-1] == state_r);

   // Stability filter: count strobes of disagreement, toggle when the window fills.
   always_comb begin
      cnt_s   = cnt_r;
      state_s = state_r;
      press_s = 1'b0;
      rel_s   = 1'b0;
      if (idle_s) begin
         cnt_s = '0;
      end else if (sample_en) begin
         if (cnt_r == CNT_MAX) begin
            cnt_s   = '0;
            state_s = ~state_r;
            press_s = ~state_r;
            rel_s   = state_r;
         end else begin
            cnt_s = cnt_r + CNT_ONE;
         end
      end else begin
         cnt_s = cnt_r;
      end
   end

   // Hold timer: runs while active, fires the long pulse once, clears on release.
   always_comb begin
      hold_s = hold_r;
      long_s = 1'b0;
      held_s = held_r;
      if (!state_r || rel_s) begin
         hold_s = '0;
         held_s = 1'b0;
      end else if (sample_en && (hold_r != HOLD_MAX)) begin
         hold_s = hold_r + HOLD_ONE;
         if (hold_r == (HOLD_MAX - HOLD_ONE)) begin
            long_s = 1'b1;
            held_s = 1'b1;
         end else begin
            long_s = 1'b0;
         end
      end else begin
         hold_s = hold_r;
      end
   end

   // State, counters and all outputs registered; reset aborts any progress.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_r  <= '0;
         cnt_r   <= '0;
         hold_r  <= '0;
         state_r <= 1'b0;
         press_r <= 1'b0;
         rel_r   <= 1'b0;
         long_r  <= 1'b0;
         held_r  <= 1'b0;
      end else begin
         sync_r  <= {sync_r[SYNC_STAGES-2:0], pol_s};
         cnt_r   <= cnt_s;
         hold_r  <= hold_s;
         state_r <= state_s;
         press_r <= press_s;
         rel_r   <= rel_s;
         long_r  <= long_s;
         held_r  <= held_s;
      end
   end

   assign state_o     = state_r;
   assign press_o     = press_r;
   assign release_o   = rel_r;
   assign long_o      = long_r;
   assign held_long_o = held_r;

endmodule

// File: rtl/multi_debouncer.sv
// N independent debounced button/switch channels sharing one sample strobe.
module multi_debouncer
   import debounce_pkg::*;
#(
   parameter int                  CHANNELS   = 4,
   parameter int                  CNT_W      = 4,
   parameter logic [CHANNELS-1:0] ACTIVE_LOW = {CHANNELS{1'b1}},
   parameter int                  HOLD_TICKS = 1000
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                sample_en,
   input  logic [CHANNELS-1:0] raw_i,
   output logic [CHANNELS-1:0] state_o,
   output logic [CHANNELS-1:0] press_o,
   output logic [CHANNELS-1:0] release_o,
   output logic [CHANNELS-1:0] long_o,
   output logic [CHANNELS-1:0] held_long_o
);

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      debounce_channel #(
         .CNT_W      (CNT_W),
         .POL_LOW    (ACTIVE_LOW[i]),
         .HOLD_TICKS (HOLD_TICKS)
      ) u_ch (
         .clk         (clk),
         .rst_n       (rst_n),
         .sample_en   (sample_en),
         .raw_i       (raw_i[i]),
         .state_o     (state_o[i]),
         .press_o     (press_o[i]),
         .release_o   (release_o[i]),
         .long_o      (long_o[i]),
         .held_long_o (held_long_o[i])
      );
   end

endmodule

// File: tb/tb_multi_debouncer.sv
// Self-checking bench for multi_debouncer: directed timing scenarios plus
// randomized stimulus compared against a behavioural per-channel model.
module tb_multi_debouncer;

   localparam int         CH   = 2;
   localparam int         CW   = 3;
   localparam logic [1:0] POL  = 2'b01;
   localparam int         HOLD = 20;
   localparam int         WIN  = 1 << CW;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          sample_en = 1'b1;
   logic [CH-1:0] raw_i = 2'b01;
   logic [CH-1:0] state_o, press_o, release_o, long_o, held_long_o;

   int checks = 0;
   int errors = 0;

   // Behavioural model: per channel, a 2-deep delay line, a run length of
   // disagreeing strobes and a count of strobes spent pressed.
   logic [CH-1:0] m_s0, m_s1, m_state, m_press, m_rel, m_long, m_held;
   int            m_run [CH];
   int            m_hold[CH];

   multi_debouncer #(
      .CHANNELS   (CH),
      .CNT_W      (CW),
      .ACTIVE_LOW (POL),
      .HOLD_TICKS (HOLD)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .sample_en   (sample_en),
      .raw_i       (raw_i),
      .state_o     (state_o),
      .press_o     (press_o),
      .release_o   (release_o),
      .long_o      (long_o),
      .held_long_o (held_long_o)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   function automatic void model_update();
      for (int c = 0; c < CH; c++) begin
         if (!rst_n) begin
            m_s0[c] = 1'b0; m_s1[c] = 1'b0; m_state[c] = 1'b0;
            m_press[c] = 1'b0; m_rel[c] = 1'b0; m_long[c] = 1'b0; m_held[c] = 1'b0;
            m_run[c] = 0; m_hold[c] = 0;
         end else begin
            logic act, was;
            act = raw_i[c] ^ POL[c];
            was = m_state[c];
            m_press[c] = 1'b0; m_rel[c] = 1'b0; m_long[c] = 1'b0;
            if (m_s1[c] == was) m_run[c] = 0;
            else if (sample_en) begin
               m_run[c]++;
               if (m_run[c] == WIN) begin
                  m_run[c] = 0;
                  m_state[c] = ~was;
                  m_press[c] = ~was;
                  m_rel[c] = was;
               end
            end
            if (!was || m_rel[c]) begin
               m_hold[c] = 0;
               m_held[c] = 1'b0;
            end else if (sample_en && m_hold[c] < HOLD) begin
               m_hold[c]++;
               if (m_hold[c] == HOLD) begin
                  m_long[c] = 1'b1;
                  m_held[c] = 1'b1;
               end
            end
            m_s1[c] = m_s0[c];
            m_s0[c] = act;
         end
      end
   endfunction

   // One clock: the model follows the active edge, the caller resumes on the falling edge.
   task automatic tick();
      @(posedge clk);
      model_update();
      @(negedge clk);
   endtask

   task automatic settle();
      raw_i = 2'b01;
      sample_en = 1'b1;
      repeat (30) tick();
   endtask

   task automatic test_reset();
      raw_i = 2'b01;
      rst_n = 1'b0;
      repeat (3) begin
         tick();
         checks++;
         if ({held_long_o, long_o, release_o, press_o, state_o} !== 10'b0) begin
            errors++;
            $display("FAIL reset_hold: outputs=%b expected=0", {held_long_o, long_o, release_o, press_o, state_o});
         end
      end
      rst_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         checks++;
         if ({held_long_o, long_o, release_o, press_o, state_o} !== 10'b0) begin
            errors++;
            $display("FAIL reset_exit cycle %0d: outputs=%b expected=0", i, {held_long_o, long_o, release_o, press_o, state_o});
         end
      end
   endtask

   task automatic test_clean_press();
      raw_i[0] = 1'b0;
      for (int i = 0; i < WIN + 1; i++) begin
         tick();
         checks++;
         if (state_o !== 2'b00 || press_o !== 2'b00) begin
            errors++;
            $display("FAIL press_early cycle %0d: state=%b press=%b expected 00/00", i, state_o, press_o);
         end
      end
      tick();
      checks++;
      if (state_o !== 2'b01 || press_o !== 2'b01) begin
         errors++;
         $display("FAIL press_edge: state=%b press=%b expected 01/01", state_o, press_o);
      end
      tick();
      checks++;
      if (state_o !== 2'b01 || press_o !== 2'b00) begin
         errors++;
         $display("FAIL press_width: state=%b press=%b expected 01/00", state_o, press_o);
      end
      raw_i[0] = 1'b1;
      for (int i = 0; i < WIN + 1; i++) begin
         tick();
         checks++;
         if (state_o !== 2'b01 || release_o !== 2'b00) begin
            errors++;
            $display("FAIL release_early cycle %0d: state=%b release=%b expected 01/00", i, state_o, release_o);
         end
      end
      tick();
      checks++;
      if (state_o !== 2'b00 || release_o !== 2'b01) begin
         errors++;
         $display("FAIL release_edge: state=%b release=%b expected 00/01", state_o, release_o);
      end
      tick();
      checks++;
      if (release_o !== 2'b00) begin
         errors++;
         $display("FAIL release_width: release=%b expected 00", release_o);
      end
   endtask

   task automatic test_glitch();
      bit seen;
      raw_i[1] = 1'b1;
      repeat (5) tick();
      raw_i[1] = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         checks++;
         if (state_o[1] !== 1'b0 || press_o[1] !== 1'b0 || release_o[1] !== 1'b0) begin
            errors++;
            $display("FAIL glitch_reject cycle %0d: state=%b press=%b release=%b expected 0", i, state_o[1], press_o[1], release_o[1]);
         end
      end
      raw_i[1] = 1'b1;
      repeat (WIN + 1) tick();
      raw_i[1] = 1'b0;
      tick();
      checks++;
      if (press_o[1] !== 1'b1 || state_o[1] !== 1'b1) begin
         errors++;
         $display("FAIL glitch_min_press: press=%b state=%b expected 1/1", press_o[1], state_o[1]);
      end
      seen = 1'b0;
      for (int i = 0; i < 15 && !seen; i++) begin
         tick();
         if (release_o[1] === 1'b1) seen = 1'b1;
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL glitch_release_timeout: release seen=%0b expected 1", seen);
      end
   endtask

   task automatic test_long_press();
      int press_t, long_t, rel_t, nlong, held_bad;
      press_t = -1; long_t = -1; rel_t = -1; nlong = 0; held_bad = 0;
      raw_i[1] = 1'b1;
      for (int t = 1; t <= 80; t++) begin
         if (t == 41) raw_i[1] = 1'b0;
         tick();
         if (press_o[1] === 1'b1) press_t = t;
         if (long_o[1] === 1'b1) begin
            nlong++;
            long_t = t;
         end
         if (release_o[1] === 1'b1) begin
            rel_t = t;
            if (held_long_o[1] !== 1'b0) held_bad++;
         end else if (long_t >= 0 && rel_t < 0) begin
            if (held_long_o[1] !== 1'b1) held_bad++;
         end else begin
            if (held_long_o[1] !== 1'b0) held_bad++;
         end
      end
      checks++;
      if (press_t != 10) begin
         errors++;
         $display("FAIL long_press_time: press at %0d expected 10", press_t);
      end
      checks++;
      if (long_t - press_t != HOLD || nlong != 1) begin
         errors++;
         $display("FAIL long_pulse: long at %0d count %0d expected at %0d count 1", long_t, nlong, press_t + HOLD);
      end
      checks++;
      if (rel_t != 50) begin
         errors++;
         $display("FAIL long_release_time: release at %0d expected 50", rel_t);
      end
      checks++;
      if (held_bad != 0) begin
         errors++;
         $display("FAIL held_long_level: %0d bad cycles expected 0", held_bad);
      end
   endtask

   task automatic test_strobe();
      bit seen;
      int bad;
      raw_i[0] = 1'b0;
      repeat (5) tick();
      sample_en = 1'b0;
      bad = 0;
      repeat (20) begin
         tick();
         if (state_o[0] !== 1'b0) bad++;
      end
      sample_en = 1'b1;
      repeat (4) begin
         tick();
         if (state_o[0] !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL strobe_gap_hold: %0d early toggles expected 0", bad);
      end
      tick();
      checks++;
      if (state_o[0] !== 1'b1 || press_o[0] !== 1'b1) begin
         errors++;
         $display("FAIL strobe_gap_resume: state=%b press=%b expected 1/1", state_o[0], press_o[0]);
      end
      raw_i[0] = 1'b1;
      seen = 1'b0;
      bad = 0;
      for (int i = 0; i < 100; i++) begin
         sample_en = (i % 4 == 0);
         tick();
         if ({held_long_o, long_o, release_o, press_o, state_o} !== {m_held, m_long, m_rel, m_press, m_state}) bad++;
         if (release_o[0] === 1'b1) seen = 1'b1;
      end
      checks++;
      if (bad != 0 || !seen) begin
         errors++;
         $display("FAIL strobe_quarter: %0d model disagreements, release seen=%0b expected 0/1", bad, seen);
      end
      sample_en = 1'b1;
   endtask

   task automatic test_simultaneous();
      raw_i = 2'b10;
      repeat (WIN + 1) tick();
      tick();
      checks++;
      if (press_o !== 2'b11 || state_o !== 2'b11) begin
         errors++;
         $display("FAIL simultaneous_press: press=%b state=%b expected 11/11", press_o, state_o);
      end
      raw_i = 2'b01;
      repeat (WIN + 1) tick();
      tick();
      checks++;
      if (release_o !== 2'b11 || state_o !== 2'b00) begin
         errors++;
         $display("FAIL simultaneous_release: release=%b state=%b expected 11/00", release_o, state_o);
      end
   endtask

   task automatic test_reset_abort();
      int bad;
      raw_i[0] = 1'b0;
      repeat (7) tick();
      rst_n = 1'b0;
      #1;
      checks++;
      if ({held_long_o, long_o, release_o, press_o, state_o} !== 10'b0) begin
         errors++;
         $display("FAIL abort_async: outputs=%b expected 0", {held_long_o, long_o, release_o, press_o, state_o});
      end
      repeat (3) tick();
      rst_n = 1'b1;
      bad = 0;
      repeat (WIN + 1) begin
         tick();
         if (state_o[0] !== 1'b0 || press_o[0] !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL abort_restart_early: %0d early cycles expected 0", bad);
      end
      tick();
      checks++;
      if (press_o[0] !== 1'b1 || state_o[0] !== 1'b1) begin
         errors++;
         $display("FAIL abort_restart_press: press=%b state=%b expected 1/1", press_o[0], state_o[0]);
      end
   endtask

   task automatic test_random();
      int left[CH];
      int bad, longs;
      bad = 0; longs = 0;
      for (int c = 0; c < CH; c++) left[c] = 0;
      for (int i = 0; i < 3000; i++) begin
         for (int c = 0; c < CH; c++) begin
            if (left[c] == 0) begin
               raw_i[c] = 1'($urandom_range(0, 1));
               left[c] = $urandom_range(1, 45);
            end else begin
               left[c]--;
            end
         end
         sample_en = (i < 1500) ? 1'b1 : 1'($urandom_range(0, 2) != 0);
         rst_n = ($urandom_range(0, 399) != 0);
         tick();
         if (long_o !== 2'b00) longs++;
         checks++;
         if ({held_long_o, long_o, release_o, press_o, state_o} !== {m_held, m_long, m_rel, m_press, m_state}) begin
            errors++;
            bad++;
            if (bad < 10)
               $display("FAIL random cycle %0d: got=%b expected=%b", i,
                        {held_long_o, long_o, release_o, press_o, state_o},
                        {m_held, m_long, m_rel, m_press, m_state});
         end
      end
      rst_n = 1'b1;
      checks++;
      if (longs == 0) begin
         errors++;
         $display("FAIL random_long_coverage: long pulses=%0d expected >0", longs);
      end
   endtask

   initial begin
      test_reset();
      test_clean_press();
      settle();
      test_glitch();
      settle();
      test_long_press();
      settle();
      test_strobe();
      settle();
      test_simultaneous();
      settle();
      test_reset_abort();
      settle();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule
